// File: rtl/serial_to_parallel_receiver.sv
// Serial-to-parallel receive end of the shift link: assembles MSB- or LSB-first bits into a
// WIDTH-bit word behind a valid/ready output register. Define PARITY_CHECK_EN for a trailing even-parity bit.
module serial_to_parallel_receiver #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ser_in,
    input  logic             ser_valid,
    input  logic             frame_start,
    input  logic             msb_first,
    output logic [WIDTH-1:0] par_out,
    output logic             par_valid,
    input  logic             par_ready,
    output logic             busy,
    output logic             overrun,
    output logic             parity_err
);

`ifdef PARITY_CHECK_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif
    localparam int CW = $clog2(FRAME_LEN + 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

`ifdef PARITY_CHECK_EN
    function automatic logic even_parity(input logic [WIDTH-1:0] data);
        return ^data;
    endfunction
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             msb_q, msb_d;
    logic [WIDTH-1:0] par_out_q, par_out_d;
    logic             par_valid_q, par_valid_d;
    logic             busy_q, busy_d;
    logic             overrun_q, overrun_d;
    logic             parity_err_q, parity_err_d;

    logic [WIDTH-1:0] shifted_s;
    logic [WIDTH-1:0] start_s;
    logic [CW-1:0]    cnt_inc_s;
    logic [WIDTH-1:0] word_s;
    logic             word_perr_s;
    logic             complete_s;

    // Next-state, shift register and output-register load decisions.
    always_comb begin
        state_d      = state_q;
        sreg_d       = sreg_q;
        cnt_d        = cnt_q;
        msb_d        = msb_q;
        par_out_d    = par_out_q;
        overrun_d    = overrun_q;
        parity_err_d = parity_err_q;
        word_s       = sreg_q;
        word_perr_s  = 1'b0;
        complete_s   = 1'b0;
        cnt_inc_s    = cnt_q + CW'(1);

        if (msb_q) begin
            shifted_s = {sreg_q[WIDTH-2:0], ser_in};
        end else begin
            shifted_s = {ser_in, sreg_q[WIDTH-1:1]};
        end

        // A new frame starts from an empty register so stale partial bits never leak in.
        if (msb_first) begin
            start_s = {{(WIDTH-1){1'b0}}, ser_in};
        end else begin
            start_s = {ser_in, {(WIDTH-1){1'b0}}};
        end

        if (par_valid_q && par_ready) begin
            par_valid_d = 1'b0;
        end else begin
            par_valid_d = par_valid_q;
        end

        case (state_q)
            IDLE: begin
                if (ser_valid && frame_start) begin
                    sreg_d  = start_s;
                    msb_d   = msb_first;
                    cnt_d   = CW'(1);
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (ser_valid && frame_start) begin
                    sreg_d = start_s;
                    msb_d  = msb_first;
                    cnt_d  = CW'(1);
                end else if (ser_valid) begin
                    if (cnt_inc_s == CW'(FRAME_LEN)) begin
                        complete_s = 1'b1;
                        cnt_d      = {CW{1'b0}};
                        state_d    = IDLE;
`ifdef PARITY_CHECK_EN
                        word_s      = sreg_q;
                        word_perr_s = even_parity(sreg_q) ^ ser_in;
                        sreg_d      = sreg_q;
`else
                        word_s      = shifted_s;
                        word_perr_s = 1'b0;
                        sreg_d      = shifted_s;
`endif
                    end else begin
                        sreg_d = shifted_s;
                        cnt_d  = cnt_inc_s;
                    end
                end else begin
                    state_d = SHIFT;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = {CW{1'b0}};
            end
        endcase

        // The waiting word may only be replaced if it is being consumed this same cycle.
        if (complete_s) begin
            if (!par_valid_q || par_ready) begin
                par_out_d    = word_s;
                par_valid_d  = 1'b1;
                parity_err_d = word_perr_s;
            end else begin
                overrun_d = 1'b1;
            end
        end else begin
            overrun_d = overrun_q;
        end

        busy_d = (state_d == SHIFT);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            sreg_q       <= {WIDTH{1'b0}};
            cnt_q        <= {CW{1'b0}};
            msb_q        <= 1'b0;
            par_out_q    <= {WIDTH{1'b0}};
            par_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sreg_q       <= sreg_d;
            cnt_q        <= cnt_d;
            msb_q        <= msb_d;
            par_out_q    <= par_out_d;
            par_valid_q  <= par_valid_d;
            busy_q       <= busy_d;
            overrun_q    <= overrun_d;
            parity_err_q <= parity_err_d;
        end
    end

    assign par_out    = par_out_q;
    assign par_valid  = par_valid_q;
    assign busy       = busy_q;
    assign overrun    = overrun_q;
    assign parity_err = parity_err_q;

endmodule

// File: tb/tb_serial_to_parallel_receiver.sv
// Bench for serial_to_parallel_receiver: frame-level model compared every cycle plus directed
// literal checks. Parity cases run when PARITY_CHECK_EN is defined.
module tb_serial_to_parallel_receiver;
    localparam int WIDTH = 8;
`ifdef PARITY_CHECK_EN
    localparam int FLEN = WIDTH + 1;
`else
    localparam int FLEN = WIDTH;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             ser_in = 1'b0;
    logic             ser_valid = 1'b0;
    logic             frame_start = 1'b0;
    logic             msb_first = 1'b0;
    logic             par_ready = 1'b0;
    logic [WIDTH-1:0] par_out;
    logic             par_valid;
    logic             busy;
    logic             overrun;
    logic             parity_err;

    int checks = 0;
    int errors = 0;
    logic cmp_en = 1'b0;

    logic [WIDTH-1:0] m_out = '0;
    logic             m_valid = 1'b0;
    logic             m_busy = 1'b0;
    logic             m_ovr = 1'b0;
    logic             m_perr = 1'b0;
    logic             m_msb = 1'b0;
    logic             bits_q[$];

    serial_to_parallel_receiver #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .ser_in(ser_in), .ser_valid(ser_valid),
        .frame_start(frame_start), .msb_first(msb_first), .par_out(par_out),
        .par_valid(par_valid), .par_ready(par_ready), .busy(busy),
        .overrun(overrun), .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Frame-level model: collect bits of a frame, build the word arithmetically on completion.
    always @(posedge clk) begin : model
        logic [WIDTH-1:0] w;
        logic prev_valid;
        logic done;
        if (!reset) begin
            m_out = '0; m_valid = 1'b0; m_busy = 1'b0; m_ovr = 1'b0; m_perr = 1'b0;
            bits_q.delete();
        end else begin
            done = 1'b0;
            w = '0;
            prev_valid = m_valid;
            if (m_valid && par_ready) m_valid = 1'b0;
            if (ser_valid) begin
                if (frame_start) begin
                    bits_q.delete();
                    bits_q.push_back(ser_in);
                    m_msb = msb_first;
                    m_busy = 1'b1;
                end else if (m_busy) begin
                    bits_q.push_back(ser_in);
                end
                if (m_busy && bits_q.size() == FLEN) begin
                    for (int i = 0; i < WIDTH; i++) begin
                        if (m_msb) w[WIDTH-1-i] = bits_q[i];
                        else       w[i] = bits_q[i];
                    end
                    done = 1'b1;
                    m_busy = 1'b0;
                end
            end
            if (done) begin
                if (!prev_valid || par_ready) begin
                    m_out = w;
                    m_valid = 1'b1;
`ifdef PARITY_CHECK_EN
                    m_perr = (^w) ^ bits_q[WIDTH];
`else
                    m_perr = 1'b0;
`endif
                end else begin
                    m_ovr = 1'b1;
                end
            end
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("par_out", 32'(par_out), 32'(m_out));
            check("par_valid", 32'(par_valid), 32'(m_valid));
            check("busy", 32'(busy), 32'(m_busy));
            check("overrun", 32'(overrun), 32'(m_ovr));
            check("parity_err", 32'(parity_err), 32'(m_perr));
        end
    end

    task automatic drive(input logic v, input logic b, input logic fs, input logic m, input logic r);
        @(negedge clk);
        ser_valid = v; ser_in = b; frame_start = fs; msb_first = m; par_ready = r;
    endtask

    task automatic send_frame(input logic [WIDTH-1:0] w, input logic m, input logic pbit,
                              input logic r, input logic gaps);
        logic b;
        for (int i = 0; i < FLEN; i++) begin
            if (i == WIDTH) b = pbit;
            else if (m)     b = w[WIDTH-1-i];
            else            b = w[i];
            drive(1'b1, b, (i == 0), m, r);
            if (gaps && (i % 3 == 1)) drive(1'b0, 1'b0, 1'b0, m, r);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b0; ser_valid = 1'b0; frame_start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        @(posedge clk);
        @(negedge clk);
        cmp_en = 1'b1;
        check("rst_par_out", 32'(par_out), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        reset = 1'b1;

        // 1: MSB-first 1,1,0,0,0,0,0,1 -> C1
        send_frame(8'hC1, 1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("t1_par_out", 32'(par_out), 32'hC1);
        check("t1_model", 32'(m_out), 32'hC1);
        check("t1_valid", 32'(par_valid), 32'h1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("t1_valid_drop", 32'(par_valid), 32'h0);
        check("t1_busy", 32'(busy), 32'h0);

        // 2: same bit sequence LSB-first -> 83
        send_frame(8'h83, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("t2_par_out", 32'(par_out), 32'h83);
        check("t2_model", 32'(m_out), 32'h83);

        // 3: consumer stalled, second word dropped
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        send_frame(8'h12, 1'b1, 1'b0, 1'b0, 1'b0);
        send_frame(8'h34, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("t3_par_out", 32'(par_out), 32'h12);
        check("t3_overrun", 32'(overrun), 32'h1);
        check("t3_valid", 32'(par_valid), 32'h1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("t3_valid_drop", 32'(par_valid), 32'h0);
        check("t3_overrun_sticky", 32'(overrun), 32'h1);

        // 4: restart mid-frame
        pulse_reset();
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        send_frame(8'h5A, 1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("t4_par_out", 32'(par_out), 32'h5A);
        check("t4_overrun", 32'(overrun), 32'h0);

        // idle bits without frame_start are ignored
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("idle_ignore_busy", 32'(busy), 32'h0);

        // 5: reset after 5 bits, then A5 with gaps
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, (i == 0), 1'b1, 1'b1);
        pulse_reset();
        check("t5_rst_par_out", 32'(par_out), 32'h0);
        check("t5_rst_valid", 32'(par_valid), 32'h0);
        check("t5_rst_busy", 32'(busy), 32'h0);
        send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("t5_par_out", 32'(par_out), 32'hA5);

`ifdef PARITY_CHECK_EN
        // 6: even parity over A5 (four ones) is 0
        send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("t6_perr0", 32'(parity_err), 32'h0);
        send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("t6_perr1", 32'(parity_err), 32'h1);
        check("t6_par_out", 32'(par_out), 32'hA5);
`endif

        repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
